row_assembler: RTL



---
 rtl/row_assembler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/row_assembler.sv
// row_assembler: packs pairs of 64-bit pixel words into 120-bit, 15-pixel rows with a one-cycle
// active-low load strobe. Optional stall/starve counters are built when ROW_ASSEMBLER_STATS_EN is defined.
module row_assembler #(
   parameter int unsigned ROWS_PER_BLOCK = 15
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [7:0]     num_blocks,
   input  logic [63:0]    in_data,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           out_stall,
   output logic [119:0]   row_out,
   output logic           load_L,
   output logic [7:0]     row_idx,
   output logic           block_done,
   output logic           done,
   output logic           busy,
   output logic [31:0]    stall_cycles,
   output logic [31:0]    starve_cycles
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LO   = 3'd1;
   localparam logic [2:0] ST_HI   = 3'd2;
   localparam logic [2:0] ST_EMIT = 3'd3;
   localparam logic [2:0] ST_FIN  = 3'd4;

   localparam logic [7:0] LAST_ROW = 8'(ROWS_PER_BLOCK - 1);

   logic [2:0]   state_q, state_d;
   logic [63:0]  lo_q, lo_d;
   logic [119:0] row_q, row_d;
   logic [7:0]   row_idx_q, row_idx_d;
   logic [7:0]   blk_cnt_q, blk_cnt_d;
   logic [7:0]   nblk_q, nblk_d;
   logic         in_ready_q, busy_q, done_q;
   logic         emit_fire, last_row, start_ok;

   assign start_ok  = (state_q == ST_IDLE) && start;
   assign emit_fire = (state_q == ST_EMIT) && !out_stall;
   assign last_row  = !(row_idx_q < LAST_ROW);

   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      row_d     = row_q;
      row_idx_d = row_idx_q;
      blk_cnt_d = blk_cnt_q;
      nblk_d    = nblk_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_blocks != 8'd0) begin
                  nblk_d    = num_blocks;
                  row_idx_d = '0;
                  blk_cnt_d = '0;
                  state_d   = ST_LO;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_LO: begin
            if (in_valid) begin
               lo_d    = in_data;
               state_d = ST_HI;
            end
         end
         ST_HI: begin
            // Top byte of the second word is padding; a row holds only 15 pixels.
            if (in_valid) begin
               row_d   = {in_data[55:0], lo_q};
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (!out_stall) begin
               if (!last_row) begin
                  row_idx_d = row_idx_q + 8'd1;
                  state_d   = ST_LO;
               end else begin
                  row_idx_d = '0;
                  blk_cnt_d = blk_cnt_q + 8'd1;
                  state_d   = ((blk_cnt_q + 8'd1) == nblk_q) ? ST_FIN : ST_LO;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lo_q       <= '0;
         row_q      <= '0;
         row_idx_q  <= '0;
         blk_cnt_q  <= '0;
         nblk_q     <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         row_q      <= row_d;
         row_idx_q  <= row_idx_d;
         blk_cnt_q  <= blk_cnt_d;
         nblk_q     <= nblk_d;
         in_ready_q <= (state_d == ST_LO) || (state_d == ST_HI);
         busy_q     <= (state_d == ST_LO) || (state_d == ST_HI) || (state_d == ST_EMIT);
         done_q     <= (state_d == ST_FIN);
      end
   end

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign row_out    = row_q;
   assign row_idx    = row_idx_q;
   // Strobe and block_done must share the cycle in which out_stall drops, so both are combinational.
   assign load_L     = !emit_fire;
   assign block_done = emit_fire && last_row;

`ifdef ROW_ASSEMBLER_STATS_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] starve_q, starve_d;

   always_comb begin
      stall_d  = stall_q;
      starve_d = starve_q;
      if (start_ok) begin
         stall_d  = '0;
         starve_d = '0;
      end else begin
         if ((state_q == ST_EMIT) && out_stall && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
         end
         if (((state_q == ST_LO) || (state_q == ST_HI)) && !in_valid && (starve_q != '1)) begin
            starve_d = starve_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q  <= '0;
         starve_q <= '0;
      end else begin
         stall_q  <= stall_d;
         starve_q <= starve_d;
      end
   end

   assign stall_cycles  = stall_q;
   assign starve_cycles = starve_q;
`else
   assign stall_cycles  = '0;
   assign starve_cycles = '0;
`endif

endmodule
